// File: rtl/branch_pkg.sv
// Shared opcode, condition-code and flag encodings for the branch resolve unit,
// plus the condition evaluator and the 2-bit saturating counter step.
package branch_pkg;

  localparam logic [4:0] OP_BCOND = 5'b11000;
  localparam logic [4:0] OP_BAL   = 5'b11001;

  localparam logic [2:0] COND_NE = 3'b000;
  localparam logic [2:0] COND_EQ = 3'b001;
  localparam logic [2:0] COND_CS = 3'b010;
  localparam logic [2:0] COND_CC = 3'b011;
  localparam logic [2:0] COND_MI = 3'b100;
  localparam logic [2:0] COND_PL = 3'b101;
  localparam logic [2:0] COND_VS = 3'b110;
  localparam logic [2:0] COND_VC = 3'b111;

  localparam int unsigned FLG_N = 3;
  localparam int unsigned FLG_Z = 2;
  localparam int unsigned FLG_C = 1;
  localparam int unsigned FLG_V = 0;

  localparam logic [1:0] CTR_RESET = 2'b01;

  function automatic logic cond_met(input logic [2:0] cond, input logic [3:0] nzcv);
    logic met;
    met = 1'b0;
    case (cond)
      COND_NE: met = ~nzcv[FLG_Z];
      COND_EQ: met =  nzcv[FLG_Z];
      COND_CS: met =  nzcv[FLG_C];
      COND_CC: met = ~nzcv[FLG_C];
      COND_MI: met =  nzcv[FLG_N];
      COND_PL: met = ~nzcv[FLG_N];
      COND_VS: met =  nzcv[FLG_V];
      COND_VC: met = ~nzcv[FLG_V];
      default: met = 1'b0;
    endcase
    return met;
  endfunction

  function automatic logic [1:0] ctr_step(input logic [1:0] ctr, input logic taken);
    logic [1:0] nxt;
    nxt = ctr;
    if (taken && ctr != 2'b11) begin
      nxt = ctr + 2'b01;
    end else if (!taken && ctr != 2'b00) begin
      nxt = ctr - 2'b01;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/bht_2bit.sv
// Branch history table of 2-bit counters: combinational read, one synchronous write,
// synchronous reset of every entry to weak not-taken.
module bht_2bit
  import branch_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             Rst,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [1:0]       rd_ctr,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [1:0]       wr_ctr
);

  logic [1:0] ctr_q [DEPTH];

  always_ff @(posedge clk) begin
    if (Rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        ctr_q[i] <= CTR_RESET;
      end
    end else if (wr_en) begin
      ctr_q[wr_idx] <= wr_ctr;
    end
  end

  assign rd_ctr = ctr_q[rd_idx];

endmodule

// File: rtl/branch_resolve_unit.sv
// MEM-stage branch resolver: NZCV PSW with same-cycle forwarding, condition evaluation,
// target adder, 2-bit direction predictor and a saturating taken-branch counter.
module branch_resolve_unit
  import branch_pkg::*;
#(
  parameter int unsigned AW    = 16,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned CW    = 16
) (
  input  logic          clk,
  input  logic          Rst,
  input  logic          ins_valid,
  input  logic [7:0]    InsM,
  input  logic [7:0]    offset,
  input  logic [AW-1:0] pc,
  input  logic          flag_we,
  input  logic [3:0]    flag_in,
  output logic [3:0]    flags,
  output logic          pred_taken,
  output logic          branch_valid,
  output logic          Branch,
  output logic [AW-1:0] target,
  output logic          mispredict,
  output logic [CW-1:0] taken_cnt
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  logic [3:0]       flags_q;
  logic             branch_valid_q, branch_q, mispredict_q;
  logic [AW-1:0]    target_q;
  logic [CW-1:0]    taken_cnt_q;

  logic [4:0]       opcode;
  logic [2:0]       cond;
  logic             is_bcond, is_bal;
  logic [3:0]       eval_flags;
  logic             taken;
  logic [IDX_W-1:0] idx;
  logic [1:0]       rd_ctr;
  logic             pred;
  logic             bht_we;
  logic [1:0]       bht_wdata;
  logic [AW-1:0]    target_d;

  always_comb begin
    opcode     = InsM[7:3];
    cond       = InsM[2:0];
    is_bcond   = (opcode == OP_BCOND);
    is_bal     = (opcode == OP_BAL);
    // Forward the ALU's flags so a compare-and-branch pair resolves without a bubble.
    eval_flags = flag_we ? flag_in : flags_q;
    taken      = ins_valid && (is_bal || (is_bcond && cond_met(cond, eval_flags)));
    idx        = pc[IDX_W-1:0];
    pred       = is_bal || (is_bcond && rd_ctr[1]);
    bht_we     = ins_valid && is_bcond;
    bht_wdata  = ctr_step(rd_ctr, taken);
    target_d   = pc + AW'(1) + AW'($signed(offset));
  end

  bht_2bit #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_bht (
    .clk    (clk),
    .Rst    (Rst),
    .rd_idx (idx),
    .rd_ctr (rd_ctr),
    .wr_en  (bht_we),
    .wr_idx (idx),
    .wr_ctr (bht_wdata)
  );

  always_ff @(posedge clk) begin
    if (Rst) begin
      flags_q        <= '0;
      branch_valid_q <= 1'b0;
      branch_q       <= 1'b0;
      mispredict_q   <= 1'b0;
      target_q       <= '0;
      taken_cnt_q    <= '0;
    end else begin
      if (flag_we) begin
        flags_q <= flag_in;
      end
      branch_valid_q <= ins_valid && (is_bcond || is_bal);
      branch_q       <= taken;
      // BAL is always predicted taken, so only Bcond can disagree with its prediction.
      mispredict_q   <= ins_valid && is_bcond && (taken != pred);
      target_q       <= target_d;
      if (taken && taken_cnt_q != '1) begin
        taken_cnt_q <= taken_cnt_q + CW'(1);
      end
    end
  end

  assign flags        = flags_q;
  assign pred_taken   = pred;
  assign branch_valid = branch_valid_q;
  assign Branch       = branch_q;
  assign target       = target_q;
  assign mispredict   = mispredict_q;
  assign taken_cnt    = taken_cnt_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: reset, all conditions, forwarding, target wrap,
// predictor training/aliasing and taken-counter saturation.
module tb_branch_resolve_unit;

  localparam logic [4:0] BC  = 5'b11000;
  localparam logic [4:0] BL  = 5'b11001;
  localparam logic [4:0] NOP = 5'b00000;

  logic        clk;
  logic        Rst;
  logic        ins_valid;
  logic [7:0]  InsM;
  logic [7:0]  offset;
  logic [15:0] pc;
  logic        flag_we;
  logic [3:0]  flag_in;
  logic [3:0]  flags;
  logic        pred_taken;
  logic        branch_valid;
  logic        Branch;
  logic [15:0] target;
  logic        mispredict;
  logic [3:0]  taken_cnt;

  int n_checks = 0;
  int n_bad    = 0;

  branch_resolve_unit #(
    .AW    (16),
    .DEPTH (16),
    .CW    (4)
  ) dut (
    .clk          (clk),
    .Rst          (Rst),
    .ins_valid    (ins_valid),
    .InsM         (InsM),
    .offset       (offset),
    .pc           (pc),
    .flag_we      (flag_we),
    .flag_in      (flag_in),
    .flags        (flags),
    .pred_taken   (pred_taken),
    .branch_valid (branch_valid),
    .Branch       (Branch),
    .target       (target),
    .mispredict   (mispredict),
    .taken_cnt    (taken_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] op, input logic [2:0] c,
                       input logic [7:0] off, input logic [15:0] p,
                       input logic we, input logic [3:0] fi);
    ins_valid = v;
    InsM      = {op, c};
    offset    = off;
    pc        = p;
    flag_we   = we;
    flag_in   = fi;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_flags(input logic [3:0] f);
    drive(1'b0, NOP, 3'd0, 8'h00, 16'h0000, 1'b1, f);
    tick();
    check_eq("flags_set", 32'(flags), 32'(f));
  endtask

  task automatic run_conds(input logic [3:0] f, input logic [7:0] exp_mask);
    set_flags(f);
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, BC, 3'(i), 8'h00, 16'h0048 + 16'(i), 1'b0, 4'h0);
      tick();
      check_eq($sformatf("cond%0d_f%0h_valid", i, f), 32'(branch_valid), 32'd1);
      check_eq($sformatf("cond%0d_f%0h_branch", i, f), 32'(Branch), 32'(exp_mask[i]));
    end
  endtask

  initial begin
    Rst = 1'b1;
    drive(1'b0, NOP, 3'd0, 8'h00, 16'h0000, 1'b0, 4'h0);
    tick();
    tick();
    Rst = 1'b0;
    check_eq("rst0_flags", 32'(flags), 32'd0);
    check_eq("rst0_cnt", 32'(taken_cnt), 32'd0);
    check_eq("rst0_valid", 32'(branch_valid), 32'd0);

    // Train idx 3 to strongly taken, then reset mid-stream.
    drive(1'b1, BC, 3'b010, 8'h00, 16'h0003, 1'b1, 4'hF);
    check_eq("pre_pred0", 32'(pred_taken), 32'd0);
    tick();
    check_eq("pre_branch", 32'(Branch), 32'd1);
    drive(1'b1, BC, 3'b010, 8'h00, 16'h0003, 1'b0, 4'h0);
    check_eq("pre_pred1", 32'(pred_taken), 32'd1);
    tick();
    check_eq("pre_cnt", 32'(taken_cnt), 32'd2);
    Rst = 1'b1;
    drive(1'b1, BL, 3'd0, 8'h10, 16'h0007, 1'b1, 4'hF);
    tick();
    tick();
    check_eq("rst_flags", 32'(flags), 32'd0);
    check_eq("rst_valid", 32'(branch_valid), 32'd0);
    check_eq("rst_branch", 32'(Branch), 32'd0);
    check_eq("rst_mispred", 32'(mispredict), 32'd0);
    check_eq("rst_target", 32'(target), 32'd0);
    check_eq("rst_cnt", 32'(taken_cnt), 32'd0);
    Rst = 1'b0;
    drive(1'b1, BC, 3'b010, 8'h00, 16'h0007, 1'b0, 4'h0);
    check_eq("rst_pred_pc7", 32'(pred_taken), 32'd0);
    drive(1'b1, BC, 3'b010, 8'h00, 16'h0003, 1'b0, 4'h0);
    check_eq("rst_pred_pc3", 32'(pred_taken), 32'd0);
    tick();
    check_eq("post_rst_valid", 32'(branch_valid), 32'd1);
    check_eq("post_rst_branch", 32'(Branch), 32'd0);
    check_eq("post_rst_mispred", 32'(mispredict), 32'd0);

    // All eight conditions under three flag patterns.
    run_conds(4'b0100, 8'b1010_1010);
    run_conds(4'b1111, 8'b0101_0110);
    run_conds(4'b0000, 8'b1010_1001);

    // Same-cycle forwarding.
    drive(1'b1, BC, 3'b001, 8'h00, 16'h0009, 1'b1, 4'b0100);
    tick();
    check_eq("fwd_branch", 32'(Branch), 32'd1);
    check_eq("fwd_flags", 32'(flags), 32'h4);

    // Target arithmetic, including wrap.
    drive(1'b1, BL, 3'd0, 8'hFE, 16'h0010, 1'b0, 4'h0);
    tick();
    check_eq("tgt_back", 32'(target), 32'h000F);
    check_eq("tgt_bal_taken", 32'(Branch), 32'd1);
    drive(1'b1, BL, 3'd0, 8'h01, 16'hFFFF, 1'b0, 4'h0);
    tick();
    check_eq("tgt_wrap", 32'(target), 32'h0001);
    drive(1'b1, NOP, 3'd1, 8'h00, 16'h0020, 1'b0, 4'h0);
    tick();
    check_eq("nonbr_valid", 32'(branch_valid), 32'd0);
    check_eq("nonbr_branch", 32'(Branch), 32'd0);

    // Predictor training on idx 5 (Z=1 from forwarding test).
    drive(1'b1, BC, 3'b001, 8'h00, 16'h0005, 1'b0, 4'h0);
    check_eq("bp_pred0", 32'(pred_taken), 32'd0);
    tick();
    check_eq("bp_mp0", 32'(mispredict), 32'd1);
    drive(1'b1, BC, 3'b001, 8'h00, 16'h0005, 1'b0, 4'h0);
    check_eq("bp_pred1", 32'(pred_taken), 32'd1);
    tick();
    check_eq("bp_mp1", 32'(mispredict), 32'd0);
    drive(1'b1, BC, 3'b001, 8'h00, 16'h0005, 1'b0, 4'h0);
    check_eq("bp_pred2", 32'(pred_taken), 32'd1);
    tick();
    check_eq("bp_mp2", 32'(mispredict), 32'd0);
    drive(1'b1, BC, 3'b001, 8'h00, 16'h0015, 1'b1, 4'b0000);
    check_eq("bp_alias_pred", 32'(pred_taken), 32'd1);
    tick();
    check_eq("bp_mp3", 32'(mispredict), 32'd1);
    check_eq("bp_nt_branch", 32'(Branch), 32'd0);
    drive(1'b1, BC, 3'b001, 8'h00, 16'h0005, 1'b0, 4'h0);
    check_eq("bp_after_dec", 32'(pred_taken), 32'd1);
    tick();

    // Counter saturation with back-to-back BALs after a fresh reset.
    Rst = 1'b1;
    drive(1'b0, NOP, 3'd0, 8'h00, 16'h0000, 1'b0, 4'h0);
    tick();
    Rst = 1'b0;
    check_eq("cnt_start", 32'(taken_cnt), 32'd0);
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, BL, 3'(i), 8'h03, 16'(i), 1'b0, 4'h0);
      if (i == 0) check_eq("bal_pred", 32'(pred_taken), 32'd1);
      tick();
      check_eq($sformatf("bal%0d_mp", i), 32'(mispredict), 32'd0);
      if (i == 13) check_eq("cnt_14", 32'(taken_cnt), 32'hE);
      if (i == 14) check_eq("cnt_15", 32'(taken_cnt), 32'hF);
    end
    check_eq("cnt_sat", 32'(taken_cnt), 32'hF);
    drive(1'b1, BC, 3'b001, 8'h00, 16'h0005, 1'b0, 4'h0);
    check_eq("tbl_pc5", 32'(pred_taken), 32'd0);
    drive(1'b1, BC, 3'b001, 8'h00, 16'h0000, 1'b0, 4'h0);
    check_eq("tbl_pc0", 32'(pred_taken), 32'd0);
    drive(1'b0, NOP, 3'd0, 8'h00, 16'h0000, 1'b0, 4'h0);
    tick();

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
